// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a small receive FIFO and a valid/ready
// read port. Framing errors and FIFO overruns are reported as one-cycle pulses.
module uart_rx #(
    parameter int FREQ_HZ    = 25_000_000,
    parameter int BAUDS      = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic       rx_i,
    output logic [7:0] rdata_o,
    output logic       rvalid_o,
    input  logic       rready_i,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int CLKS_PER_BIT = FREQ_HZ / BAUDS;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int AW           = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT0     = {(AW+1){1'b0}};
    localparam logic [AW:0]   CNT1     = (AW+1)'(1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    logic [1:0]    sync_r;
    logic          rx_s;
    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic          frame_err_r;

    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          overrun_r;

    logic          push_s;
    logic          pop_s;
    logic          full_s;
    logic          push_ok_s;

    assign rx_s = sync_r[1];

    // Two-flop synchroniser bringing the asynchronous line into the clk domain.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], rx_i};
        end
    end

    // Frame decoder: start validation, mid-bit data sampling, stop check, break hold-off.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            bit_idx_r   <= 3'd0;
            shift_r     <= 8'h00;
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= CNT_ZERO;
                    if (!rx_s) begin
                        state_r <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_r == CNT_HALF) begin
                        cnt_r <= CNT_ZERO;
                        if (!rx_s) begin
                            state_r   <= ST_DATA;
                            bit_idx_r <= 3'd0;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (cnt_r == CNT_MAX) begin
                        cnt_r   <= CNT_ZERO;
                        shift_r <= {rx_s, shift_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (cnt_r == CNT_MAX) begin
                        cnt_r <= CNT_ZERO;
                        if (rx_s) begin
                            state_r <= ST_IDLE;
                        end else begin
                            frame_err_r <= 1'b1;
                            state_r     <= ST_BREAK;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_BREAK: begin
                    cnt_r <= CNT_ZERO;
                    if (rx_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    // A good stop bit hands the assembled byte to the FIFO in the sampling cycle.
    assign push_s    = (state_r == ST_STOP) && (cnt_r == CNT_MAX) && rx_s;
    assign pop_s     = (count_r != CNT0) && rready_i;
    assign full_s    = (count_r == FULL_CNT);
    assign push_ok_s = push_s && (!full_s || pop_s);

    // Receive FIFO; a push into a full FIFO survives only if a pop frees a slot the same cycle.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_r  <= PTR_ZERO;
            rd_ptr_r  <= PTR_ZERO;
            count_r   <= CNT0;
            overrun_r <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else begin
            overrun_r <= push_s && full_s && !pop_s;
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= shift_r;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CNT1;
                2'b01:   count_r <= count_r - CNT1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata_o     = mem_r[rd_ptr_r];
    assign rvalid_o    = (count_r != CNT0);
    assign frame_err_o = frame_err_r;
    assign overrun_o   = overrun_r;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed 8N1 stimulus against a queue-based
// reference of the receive FIFO contents and expected error pulse counts.
module tb_uart_rx;

    localparam int DEPTH = 4;
    localparam int CPB   = 10;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       rx_i = 1'b1;
    logic [7:0] rdata_o;
    logic       rvalid_o;
    logic       rready_i = 1'b1;
    logic       frame_err_o;
    logic       overrun_o;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int exp_fe = 0;
    int exp_ov = 0;
    bit rand_mode = 1'b0;
    bit hold_prev = 1'b0;
    logic [7:0] hold_data = 8'h00;
    logic [7:0] model_q[$];

    uart_rx #(.FREQ_HZ(1_000_000), .BAUDS(100_000), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_i(reset_i), .rx_i(rx_i),
        .rdata_o(rdata_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
        .frame_err_o(frame_err_o), .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    // Compare one observed value with its expected value and tally the result.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge; in random mode the consumer readiness is re-rolled.
    task automatic tick();
        @(negedge clk);
        if (rand_mode) rready_i = 1'($urandom_range(0, 1));
    endtask

    // Drive one frame; the reference decides up front whether the byte is stored or dropped.
    task automatic send_frame(input logic [7:0] b, input logic stop, input bit pulse, input bit latchk);
        if (stop) begin
            if (pulse || rready_i || rand_mode || model_q.size() < DEPTH) model_q.push_back(b);
            else exp_ov++;
        end else begin
            exp_fe++;
        end
        rx_i = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (CPB) tick();
        end
        rx_i = stop;
        for (int j = 1; j <= CPB; j++) begin
            tick();
            if (pulse && j == 7) rready_i = 1'b1;
            if (pulse && j == 8) rready_i = 1'b0;
            if (latchk && j == 7) begin
                #1;
                check("rvalid_before_stop", {31'd0, rvalid_o}, 32'd0);
            end
            if (latchk && j == 8) begin
                #1;
                check("rvalid_after_stop", {31'd0, rvalid_o}, 32'd1);
                check("rdata_after_stop", {24'd0, rdata_o}, {24'd0, b});
            end
        end
        rx_i = 1'b1;
    endtask

    // Wait, with a cycle budget, for every expected byte to be consumed.
    task automatic wait_drain();
        for (int i = 0; i < 3000 && model_q.size() != 0; i++) tick();
        repeat (3) tick();
        check("drain_left", model_q.size(), 32'd0);
    endtask

    // Monitor: count pulses, score popped bytes, and verify the head is stable while stalled.
    always begin
        @(negedge clk);
        #1;
        if (frame_err_o === 1'b1) fe_cnt++;
        if (overrun_o === 1'b1) ov_cnt++;
        if (hold_prev && rvalid_o) check("hold", {24'd0, rdata_o}, {24'd0, hold_data});
        if (rvalid_o && rready_i) begin
            if (model_q.size() == 0) check("pop_q_size", model_q.size(), 32'd1);
            else check("pop_data", {24'd0, rdata_o}, {24'd0, model_q.pop_front()});
        end
        hold_prev = rvalid_o && !rready_i;
        hold_data = rdata_o;
    end

    // Safety net so the run can never hang.
    initial begin
        #500_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        int base_fe;
        logic [7:0] rb;
        logic [7:0] ab;
        repeat (3) tick();
        #1;
        check("rst_rdata", {24'd0, rdata_o}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
        check("rst_ferr", {31'd0, frame_err_o}, 32'd0);
        check("rst_ovr", {31'd0, overrun_o}, 32'd0);
        reset_i = 1'b0;
        repeat (5) tick();

        // Reset mid-frame during data bit 3: nothing may be stored.
        ab = 8'hC3;
        rx_i = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 3; i++) begin
            rx_i = ab[i];
            repeat (CPB) tick();
        end
        rx_i = ab[3];
        repeat (5) tick();
        #3 reset_i = 1'b1;
        #1;
        check("midrst_rvalid", {31'd0, rvalid_o}, 32'd0);
        check("midrst_ferr", {31'd0, frame_err_o}, 32'd0);
        rx_i = 1'b1;
        repeat (3) tick();
        reset_i = 1'b0;
        repeat (200) tick();
        #1;
        check("postrst_rvalid", {31'd0, rvalid_o}, 32'd0);
        check("postrst_ferr_cnt", fe_cnt, exp_fe);
        check("postrst_ovr_cnt", ov_cnt, exp_ov);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        repeat (4) tick();
        wait_drain();

        // Single byte with latency check.
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        repeat (4) tick();
        wait_drain();

        // Short glitch on an idle line.
        base_fe = fe_cnt;
        rx_i = 1'b0;
        repeat (3) tick();
        rx_i = 1'b1;
        repeat (150) tick();
        #1;
        check("glitch_rvalid", {31'd0, rvalid_o}, 32'd0);
        check("glitch_ferr", fe_cnt, base_fe);
        send_frame(8'h96, 1'b1, 1'b0, 1'b1);
        repeat (4) tick();
        wait_drain();

        // Bad stop bit then a long break: exactly one framing error.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        rx_i = 1'b0;
        repeat (50) tick();
        rx_i = 1'b1;
        repeat (10) tick();
        check("break_ferr_cnt", fe_cnt, exp_fe);
        check("break_rvalid", {31'd0, rvalid_o}, 32'd0);
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        repeat (4) tick();
        wait_drain();

        // Overrun: five bytes into a four-entry FIFO with the consumer stalled.
        rready_i = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, 1'b0);
            repeat (2) tick();
        end
        check("ovr_cnt", ov_cnt, exp_ov);
        check("ovr_expected_one", exp_ov, 32'd1);
        check("ovr_head", {24'd0, rdata_o}, 32'h01);
        rready_i = 1'b1;
        wait_drain();

        // Full FIFO with a pop coinciding with the push of 0x77.
        rready_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, 1'b0);
            repeat (2) tick();
        end
        send_frame(8'h77, 1'b1, 1'b1, 1'b0);
        repeat (4) tick();
        check("full_pop_ovr_cnt", ov_cnt, exp_ov);
        check("full_pop_head", {24'd0, rdata_o}, 32'h02);
        rready_i = 1'b1;
        wait_drain();

        // Randomized traffic with a randomly stalling consumer and occasional bad stop bits.
        rand_mode = 1'b1;
        for (int n = 0; n < 24; n++) begin
            logic good;
            rb = 8'($urandom);
            good = ($urandom_range(0, 7) != 0);
            send_frame(rb, good, 1'b0, 1'b0);
            repeat (good ? $urandom_range(0, 6) : $urandom_range(4, 8)) tick();
        end
        rand_mode = 1'b0;
        rready_i = 1'b1;
        wait_drain();

        check("final_ferr_cnt", fe_cnt, exp_fe);
        check("final_ovr_cnt", ov_cnt, exp_ov);
        #1;
        check("final_rvalid", {31'd0, rvalid_o}, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
